// File: rtl/flag_unit_if.sv
// rtl/flag_unit_if.sv - ALU/branch request and flag/decision signals for flag_unit
// master drives ALU results and branch requests; slave is the flag unit itself.
interface flag_unit_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_overflow;
  logic             set_flags;
  logic             br_valid;
  logic [1:0]       br_type;
  logic [3:0]       br_cond;
  logic [WIDTH-1:0] cb_value;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             br_done;
  logic             br_taken;

  modport master (
    output alu_result, alu_carry, alu_overflow, set_flags,
    output br_valid, br_type, br_cond, cb_value,
    input  flag_n, flag_z, flag_c, flag_v, br_done, br_taken
  );

  modport slave (
    input  alu_result, alu_carry, alu_overflow, set_flags,
    input  br_valid, br_type, br_cond, cb_value,
    output flag_n, flag_z, flag_c, flag_v, br_done, br_taken
  );
endinterface

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - NZCV latch and registered branch decision (B.cond/CBZ/CBNZ/B)
// Define FLAG_FORWARD_EN to let a B.cond see flags produced in the same cycle.
module flag_unit #(
  parameter int WIDTH = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  flag_unit_if.slave   bus
);

  localparam logic [1:0] BR_COND  = 2'b00;
  localparam logic [1:0] BR_CBZ   = 2'b01;
  localparam logic [1:0] BR_CBNZ  = 2'b10;

  logic [3:0] nzcv_q, nzcv_d;
  logic       br_done_q, br_done_d;
  logic       br_taken_q, br_taken_d;

  logic       z_new, n_new, cb_zero;
  logic [3:0] nzcv_new;
  logic [3:0] eval_flags;
  logic       cond_true;
  logic       taken;

  // Wide zero detects: OR-reduce then invert.
  assign z_new    = ~(|bus.alu_result);
  assign cb_zero  = ~(|bus.cb_value);
  assign n_new    = bus.alu_result[WIDTH-1];
  assign nzcv_new = {n_new, z_new, bus.alu_carry, bus.alu_overflow};

`ifdef FLAG_FORWARD_EN
  assign eval_flags = bus.set_flags ? nzcv_new : nzcv_q;
`else
  assign eval_flags = nzcv_q;
`endif

  always_comb begin
    logic fn, fz, fc, fv;
    cond_true = 1'b0;
    {fn, fz, fc, fv} = eval_flags;
    unique case (bus.br_cond)
      4'b0000: cond_true = fz;
      4'b0001: cond_true = !fz;
      4'b0010: cond_true = fc;
      4'b0011: cond_true = !fc;
      4'b0100: cond_true = fn;
      4'b0101: cond_true = !fn;
      4'b0110: cond_true = fv;
      4'b0111: cond_true = !fv;
      4'b1000: cond_true = fc & !fz;
      4'b1001: cond_true = !(fc & !fz);
      4'b1010: cond_true = (fn == fv);
      4'b1011: cond_true = (fn != fv);
      4'b1100: cond_true = !fz & (fn == fv);
      4'b1101: cond_true = !(!fz & (fn == fv));
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    taken = 1'b1;
    unique case (bus.br_type)
      BR_COND: taken = cond_true;
      BR_CBZ:  taken = cb_zero;
      BR_CBNZ: taken = !cb_zero;
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    nzcv_d     = bus.set_flags ? nzcv_new : nzcv_q;
    br_done_d  = bus.br_valid;
    br_taken_d = bus.br_valid ? taken : br_taken_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nzcv_q     <= 4'b0000;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      nzcv_q     <= nzcv_d;
      br_done_q  <= br_done_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign bus.flag_n   = nzcv_q[3];
  assign bus.flag_z   = nzcv_q[2];
  assign bus.flag_c   = nzcv_q[1];
  assign bus.flag_v   = nzcv_q[0];
  assign bus.br_done  = br_done_q;
  assign bus.br_taken = br_taken_q;

endmodule

// File: doc/flag_unit.md
# flag_unit

Condition-flag stage directly downstream of the ALU and its 64-bit zero detector. Derives N and Z from the ALU result and latches NZCV on flag-setting instructions. Evaluates branch requests (B.cond, CBZ, CBNZ, B) against the latched flags or a 64-bit test operand, and returns a registered taken/not-taken decision one cycle later.

## Interface
Parameters
- WIDTH, 64, datapath width of `alu_result` and `cb_value`

Ports
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- alu_result  in  WIDTH  ALU output for the current instruction
- alu_carry  in  1  ALU carry-out
- alu_overflow  in  1  ALU signed overflow
- set_flags  in  1  update NZCV this cycle
- br_valid  in  1  branch request present this cycle
- br_type  in  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 unconditional B
- br_cond  in  4  condition code for B.cond
- cb_value  in  WIDTH  register operand tested by CBZ/CBNZ
- flag_n, flag_z, flag_c, flag_v  out  1 each  latched NZCV
- br_done  out  1  decision valid, one-cycle pulse
- br_taken  out  1  branch decision, meaningful only when `br_done`=1

## Operation
- Reset: when `reset_n`=0 at a rising edge, all outputs clear to 0, including NZCV, `br_done`, and `br_taken`.
- Zero detect: Z_new = 1 iff `alu_result` == 0 across all WIDTH bits. CBZ test = 1 iff `cb_value` == 0. Both use an OR-reduction followed by an inverter.
- N_new = `alu_result`[WIDTH-1]. C_new = `alu_carry`. V_new = `alu_overflow`.
- `set_flags`=1: NZCV <= {N_new, Z_new, C_new, V_new} at the edge. Otherwise NZCV holds.
- Condition evaluation for B.cond uses flags F (source set by the Configuration section):
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !(C&!Z).
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: the inverse of GT.
  - 1110 and 1111: always true.
- CBZ: taken = (`cb_value`==0). CBNZ: taken = (`cb_value`!=0). CBZ and CBNZ ignore NZCV and `br_cond`.
- Unconditional B: taken = 1.
- `br_valid`=0: `br_done` <= 0. `br_taken` holds its previous value.
- Back-to-back requests are accepted every cycle. There is no stall and no backpressure.

## Timing
- Flag latency: `set_flags` at edge t makes the new NZCV visible on the outputs after edge t.
- Branch latency: a request sampled at edge t produces `br_done`=1 and `br_taken` after edge t, held for exactly one cycle unless another request arrives.
- Simultaneous `set_flags` and a B.cond request in the same cycle: the flag source is set by the Configuration section.
- A flag update and a CBZ/CBNZ/B request in the same cycle do not interact.
- Reset mid-operation: a request in the reset cycle is dropped, and `br_done` is 0 in the following cycle. A `set_flags` in the reset cycle is ignored.
- After reset with no `set_flags`: B.cond evaluates against NZCV=0000. EQ is not taken, NE is taken, and AL is taken.

## Configuration
- `FLAG_FORWARD_EN` defined: when `set_flags` and a B.cond request coincide, F = {N_new, Z_new, C_new, V_new}. This is same-cycle forwarding.
- `FLAG_FORWARD_EN` undefined: F is always the latched NZCV. A B.cond issued in the same cycle as `set_flags` sees the old flags.
- Latched NZCV behaviour is identical in both builds.

## Test plan
- Reset, then set_flags with `alu_result`=0, carry=1, overflow=0 -> after one edge NZCV=0110. Then B.cond EQ -> `br_done`=1, `br_taken`=1 one cycle later.
- set_flags with `alu_result`=64'h8000_0000_0000_0000, overflow=0 -> NZCV=1000. Then B.cond LT -> taken. GE -> not taken. GT -> not taken.
- CBZ with `cb_value`=0 -> taken. CBNZ with `cb_value`=1 -> taken. CBZ with `cb_value`=64'd497403948 -> not taken. NZCV is unchanged throughout.
- Flags hold NZCV=0000, then same cycle: set_flags with `alu_result`=0 plus B.cond EQ:
  - With `FLAG_FORWARD_EN`: taken.
  - Without it: not taken.
  - Both builds: NZCV=0100 afterwards.
- Three back-to-back requests (B, CBNZ `cb_value`=0, B.cond 1111) -> `br_done` high for 3 consecutive cycles with `br_taken`=1,0,1.
- `reset_n` driven low in the same cycle as set_flags and br_valid -> NZCV=0000 and `br_done`=0 on the next cycle.
